// File: rtl/neuron_mac_acc.sv
// Serial fixed-point multiply-accumulate for one neuron pre-activation:
// out = bias + sum(x[i]*w[i]), with saturation of the Q result to DWIDTH bits.
module neuron_mac_acc #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 16,
  parameter int NIN    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DWIDTH-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] w,
  output logic              busy,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out
);

  localparam int ACC_W = 2*DWIDTH + 8;
  localparam logic [7:0] LAST = 8'(NIN - 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic [7:0]               count;

  logic signed [2*DWIDTH-1:0] x_ext;
  logic signed [2*DWIDTH-1:0] w_ext;
  logic signed [2*DWIDTH-1:0] product;
  logic signed [ACC_W-1:0]    product_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic                       fits;
  logic [DWIDTH-1:0]          sat_result;

  assign x_ext       = {{DWIDTH{x[DWIDTH-1]}}, x};
  assign w_ext       = {{DWIDTH{w[DWIDTH-1]}}, w};
  assign product     = x_ext * w_ext;
  assign product_ext = {{(ACC_W-2*DWIDTH){product[2*DWIDTH-1]}}, product};

  // Bias is aligned to the product scale (2*FRAC fractional bits).
  assign bias_ext = {{(ACC_W-DWIDTH){bias[DWIDTH-1]}}, bias} <<< FRAC;

  // The result fits when every bit above the output sign bit equals it.
  assign shifted = acc >>> FRAC;
  assign fits    = (&shifted[ACC_W-1:DWIDTH-1]) | ~(|shifted[ACC_W-1:DWIDTH-1]);

  always_comb begin
    sat_result = shifted[DWIDTH-1:0];
    if (!fits) begin
      if (shifted[ACC_W-1])
        sat_result = {1'b1, {(DWIDTH-1){1'b0}}};
      else
        sat_result = {1'b0, {(DWIDTH-1){1'b1}}};
    end
  end

  assign in_ready = (state == ACC);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= bias_ext;
            count <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (in_valid) begin
            acc   <= acc + product_ext;
            count <= count + 8'd1;
            if (count == LAST)
              state <= DONE;
          end
        end
        DONE: begin
          out       <= sat_result;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Directed, table-driven bench for neuron_mac_acc with NIN=4 in Q16.16,
// plus hand sequences for reset abort and back-to-back neurons.
module tb_neuron_mac_acc;

  localparam int DW  = 32;
  localparam int NIN = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x;
  logic [DW-1:0] w;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct {
    string               name;
    logic [31:0]         bias;
    logic [3:0][31:0]    xs;
    logic [3:0][31:0]    ws;
    logic [15:0]         gaps;
    bit                  mid_start;
    logic [31:0]         exp_out;
  } vec_t;

  vec_t vecs[12];

  neuron_mac_acc #(.DWIDTH(DW), .FRAC(16), .NIN(NIN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .w         (w),
    .busy      (busy),
    .out_valid (out_valid),
    .out       (out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (out_valid) pulses++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string n, logic [31:0] b,
                              logic [31:0] x0, logic [31:0] x1, logic [31:0] x2, logic [31:0] x3,
                              logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3,
                              logic [15:0] g, bit mid, logic [31:0] e);
    vec_t v;
    v.name = n;
    v.bias = b;
    v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
    v.ws[0] = w0; v.ws[1] = w1; v.ws[2] = w2; v.ws[3] = w3;
    v.gaps = g;
    v.mid_start = mid;
    v.exp_out = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the last pair is driven.
  task automatic applyStimulus(input vec_t v, input logic [31:0] held);
    int k = 0;
    int cyc = 0;
    start    = 1'b1;
    bias     = v.bias;
    in_valid = 1'b0;
    @(negedge clk);
    while (k < NIN && cyc < 40) begin
      check({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      check({v.name, " out held"}, out, held);
      start    = (v.mid_start && cyc == 2);
      in_valid = (cyc < 16) ? v.gaps[cyc] : 1'b1;
      if (in_valid) begin
        x = v.xs[k];
        w = v.ws[k];
        k++;
      end else begin
        x = 32'hDEADBEEF;
        w = 32'h7654_3210;
      end
      cyc++;
      if (k < NIN) @(negedge clk);
    end
  endtask

  // Returns at the negedge where out_valid is observed high.
  task automatic checkOutput(input string name, input logic [31:0] exp);
    int lat = 0;
    bit seen = 0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      lat++;
      if (out_valid) seen = 1;
    end
    if (!seen) begin
      check({name, " out_valid timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " latency"}, lat, 32'd2);
      check({name, " out"}, out, exp);
    end
  endtask

  initial begin
    logic [31:0] held;
    int p0;

    vecs[0]  = mk("basic", 32'h00008000, 32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00004000,
                  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'hFFFF, 0, 32'h00034000);
    vecs[1]  = mk("gapped", 32'h00008000, 32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00004000,
                  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'hFF59, 0, 32'h00034000);
    vecs[2]  = mk("sat_pos", 32'h0, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000,
                  32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000, 16'hFFFF, 0, 32'h7FFFFFFF);
    vecs[3]  = mk("sat_neg", 32'h0, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                  32'h00020000, 32'h00020000, 32'h00020000, 32'h00020000, 16'hFFFF, 0, 32'h80000000);
    vecs[4]  = mk("trunc_pos1", 32'h0, 32'h00000001, 32'h0, 32'h0, 32'h0,
                  32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 16'hFFFF, 0, 32'h00000000);
    vecs[5]  = mk("trunc_neg1", 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0,
                  32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 16'hFFFF, 0, 32'hFFFFFFFF);
    vecs[6]  = mk("trunc_pos4", 32'h0, 32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001,
                  32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 16'hFFFF, 0, 32'h00000002);
    vecs[7]  = mk("trunc_neg4", 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000, 16'hFFFF, 0, 32'hFFFFFFFE);
    vecs[8]  = mk("mid_start", 32'h00008000, 32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00004000,
                  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'hFFFF, 1, 32'h00034000);
    vecs[9]  = mk("neg_bias", 32'hFFFF0000, 32'h00030000, 32'hFFFE0000, 32'h00008000, 32'h00010000,
                  32'h00020000, 32'h00018000, 32'hFFFF0000, 32'h00004000, 16'hFFFF, 0, 32'h0001C000);
    vecs[10] = mk("min_edge", 32'h80000000, 32'h00000001, 32'h0, 32'h0, 32'h0,
                  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'hFFFF, 0, 32'h80000001);
    vecs[11] = mk("max_edge", 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h0, 32'h0,
                  32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 16'hFFFF, 0, 32'h7FFFFFFF);

    reset = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; x = '0; w = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset out", out, 32'd0);

    held = 32'd0;
    for (int i = 0; i < 12; i++) begin
      p0 = pulses;
      applyStimulus(vecs[i], held);
      checkOutput(vecs[i].name, vecs[i].exp_out);
      @(negedge clk);
      check({vecs[i].name, " pulse end"}, {31'b0, out_valid}, 32'd0);
      check({vecs[i].name, " out stable"}, out, vecs[i].exp_out);
      check({vecs[i].name, " pulse count"}, pulses - p0, 32'd1);
      held = vecs[i].exp_out;
    end

    // Reset after two accepted pairs discards the partial sum.
    $display("[TB] reset abort sequence");
    p0 = pulses;
    start = 1'b1; bias = 32'h00008000;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; x = vecs[0].xs[k]; w = vecs[0].ws[k];
      @(negedge clk);
    end
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort in_ready", {31'b0, in_ready}, 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort out", out, 32'd0);
    in_valid = 1'b1; x = 32'h00050000; w = 32'h00050000;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    check("abort busy idle", {31'b0, busy}, 32'd0);
    check("abort no pulse", pulses - p0, 32'd0);
    check("abort out idle", out, 32'd0);

    // Fresh start after the abort.
    applyStimulus(vecs[0], 32'd0);
    checkOutput("fresh", 32'h00034000);
    @(negedge clk);

    // Back-to-back: second start issued in the out_valid cycle.
    $display("[TB] back-to-back sequence");
    p0 = pulses;
    applyStimulus(vecs[9], 32'h00034000);
    checkOutput("b2b first", 32'h0001C000);
    applyStimulus(vecs[0], 32'h0001C000);
    checkOutput("b2b second", 32'h00034000);
    @(negedge clk);
    check("b2b pulse count", pulses - p0, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
